// File: rtl/key_tone_uart.sv
// key_tone_uart: keypad event FIFO feeding an 8N1 UART transmitter and a timed square-wave tone engine.
module key_tone_uart #(
  parameter int KEY_W     = 4,
  parameter int DEPTH     = 8,
  parameter int BAUD_DIV  = 5208,
  parameter int NOTE_CYC  = 25000000,
  parameter int TONE_BASE = 95556,
  parameter int TONE_STEP = 4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [KEY_W-1:0]         key_code,
  input  logic [1:0]               mode,
  output logic                     tx_out,
  output logic                     piano_out,
  output logic [KEY_W-1:0]         last_code,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(NOTE_CYC + 1);
  localparam int HW = $clog2(TONE_BASE + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [KEY_W-1:0] mem [DEPTH];
  logic [KEY_W-1:0] rd_code;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg;
  logic tone_act;
  logic [NW-1:0] note_cnt;
  logic [HW-1:0] half, ph;
  logic accept, push, pop, start_uart, start_tone, baud_end;
  assign rd_code    = mem[rd_ptr];
  assign fifo_full  = fifo_count == CW'(DEPTH);
  assign accept     = key_valid && mode != 2'b11;
  assign pop        = fifo_count != '0 && (mode == 2'b00 ? state == IDLE && !tone_act :
                                           mode == 2'b01 ? state == IDLE :
                                           mode == 2'b10 ? !tone_act : 1'b1);
  assign push       = accept && (!fifo_full || pop);
  assign start_uart = pop && !mode[1];
  assign start_tone = pop && !mode[0];
  assign baud_end   = baud == BW'(BAUD_DIV - 1);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= key_code;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_code  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (push) last_code <= key_code;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (accept && !push) overflow <= 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    if (state == IDLE) begin
      if (start_uart) begin
        state_n = START;
        baud_n  = '0;
        bit_n   = '0;
      end
    end else begin
      baud_n = baud_end ? '0 : baud + BW'(1);
      if (baud_end) state_n = state == START ? DATA : state == STOP ? IDLE : bit_idx == 3'd7 ? STOP : DATA;
      if (baud_end && state == DATA) bit_n = bit_idx + 3'd1;
    end
  end
  // tx_out and busy are registered, so both lag the state register by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      if (start_uart) shreg <= 8'(rd_code);
      tx_out  <= state == START ? 1'b0 : state == DATA ? shreg[bit_idx] : 1'b1;
      busy    <= state != IDLE || tone_act;
    end
  end
  // ph counts cycles spent at the current level; the note is cut off after NOTE_CYC output cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_act  <= 1'b0;
      note_cnt  <= '0;
      half      <= '0;
      ph        <= '0;
      piano_out <= 1'b0;
    end else if (start_tone) begin
      tone_act <= 1'b1;
      note_cnt <= '0;
      half     <= HW'(TONE_BASE - TONE_STEP * int'(rd_code));
    end else if (tone_act) begin
      if (note_cnt == NW'(NOTE_CYC)) begin
        tone_act  <= 1'b0;
        piano_out <= 1'b0;
      end else begin
        note_cnt  <= note_cnt + NW'(1);
        piano_out <= note_cnt == '0 ? 1'b1 : ph == half ? !piano_out : piano_out;
        ph        <= note_cnt == '0 || ph == half ? HW'(1) : ph + HW'(1);
      end
    end
  end
endmodule
